zbt_point_writer: RTL

- Parametrised point-pattern writer that streams calibration/test points into ZBT SRAM through a valid/ready write port.
- Successor to the free-running fixed-table address/value generator. Adds:
  - a start/busy/done control interface;
  - a configurable point count and base address;
  - two generated pattern modes, diagonal and raster grid;
  - alternating colours and optional continuous looping.
- Sits between the scanner control FSM and the ZBT controller write port. The display path reads the same ZBT region.

---
 rtl/zbt_point_pkg.sv | 44 ++++
 rtl/zbt_point_gen.sv | 122 ++++++++++++
 rtl/zbt_point_writer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/zbt_point_pkg.sv
// -----------------------------------------------------------------------------
// zbt_point_pkg
//   Shared types and helpers for the ZBT point-pattern writer and the display
//   readback path that decodes the same words.
//   - state_e   : writer control states (IDLE / WRITE / DONE)
//   - mode_e    : pattern select (MODE_DIAG / MODE_RASTER)
//   - pack_point: packs x, y and colour into a ZBT word laid out as
//                 {zero pad, x, y, colour}, colour in the LSBs.
// -----------------------------------------------------------------------------
package zbt_point_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_DIAG   = 1'b0,
    MODE_RASTER = 1'b1
  } mode_e;

  // Widest word pack_point can build; callers size the result down to DATA_W.
  localparam int unsigned PACK_MAX_W = 128;

  // Field widths are arguments so the writer and the readback decoder can
  // share one definition regardless of how each is parameterised.
  function automatic logic [PACK_MAX_W-1:0] pack_point(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] colour,
    input int unsigned coord_w,
    input int unsigned color_w
  );
    logic [PACK_MAX_W-1:0] coord_mask;
    logic [PACK_MAX_W-1:0] color_mask;
    coord_mask = (PACK_MAX_W'(1) << coord_w) - PACK_MAX_W'(1);
    color_mask = (PACK_MAX_W'(1) << color_w) - PACK_MAX_W'(1);
    return ((PACK_MAX_W'(x) & coord_mask) << (coord_w + color_w))
         | ((PACK_MAX_W'(y) & coord_mask) << color_w)
         |  (PACK_MAX_W'(colour) & color_mask);
  endfunction

endpackage

// File: rtl/zbt_point_gen.sv
// -----------------------------------------------------------------------------
// zbt_point_gen
//   Point sequencer for the ZBT point writer. Holds the point index, raster
//   column/row counters and the x/y/colour running values. Coordinates are
//   produced with running adders only; they wrap modulo 2^COORD_W.
//
// Ports
//   clk       : system clock
//   reset_n   : synchronous active-low reset (clears counters and outputs)
//   clear_i   : load point 0 (takes priority over advance_i)
//   advance_i : step to the next point
//   mode_i    : pattern select used by clear_i / advance_i (0 diag, 1 raster)
//   x_o, y_o  : current point coordinates
//   color_o   : current point colour
//   last_o    : current point is index NUM_POINTS-1
// -----------------------------------------------------------------------------
module zbt_point_gen
  import zbt_point_pkg::*;
#(
  parameter int unsigned          COORD_W    = 10,
  parameter int unsigned          COLOR_W    = 10,
  parameter int unsigned          NUM_POINTS = 8,
  parameter int unsigned          X0         = 100,
  parameter int unsigned          Y0         = 100,
  parameter int unsigned          STEP       = 100,
  parameter int unsigned          GRID_W     = 4,
  parameter logic [COLOR_W-1:0]   COLOR_A    = '0,
  parameter logic [COLOR_W-1:0]   COLOR_B    = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               advance_i,
  input  logic               mode_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [COLOR_W-1:0] color_o,
  output logic               last_o
);

  localparam int unsigned IDX_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam int unsigned COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned ROW_W = IDX_W;

  localparam logic [COORD_W-1:0] X0_C   = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y0_C   = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);

  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [COL_W-1:0]   col_q,   col_d;
  logic [ROW_W-1:0]   row_q,   row_d;
  logic [COORD_W-1:0] x_q,     x_d;
  logic [COORD_W-1:0] y_q,     y_d;
  logic [COLOR_W-1:0] color_q, color_d;

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first so
    // that no branch leaves a variable unassigned and infers a latch.
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;

    if (clear_i) begin
      idx_d   = '0;
      col_d   = '0;
      row_d   = '0;
      x_d     = X0_C;
      // The diagonal is x == y from the same origin, so it starts at X0 on
      // both axes; raster rows start at Y0.
      y_d     = (mode_i == MODE_RASTER) ? Y0_C : X0_C;
      color_d = COLOR_A;
    end else if (advance_i) begin
      idx_d   = idx_q + IDX_W'(1);
      // Next index has the opposite parity to the current one.
      color_d = idx_q[0] ? COLOR_A : COLOR_B;
      if (mode_i == MODE_RASTER) begin
        if (col_q == COL_W'(GRID_W - 1)) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
          x_d   = X0_C;
          y_d   = y_q + STEP_C;
        end else begin
          col_d = col_q + COL_W'(1);
          x_d   = x_q + STEP_C;
        end
      end else begin
        x_d = x_q + STEP_C;
        y_d = y_q + STEP_C;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is
  // irrelevant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign color_o = color_q;
  assign last_o  = (idx_q == IDX_W'(NUM_POINTS - 1));

endmodule

// File: rtl/zbt_point_writer.sv
// -----------------------------------------------------------------------------
// zbt_point_writer
//   Streams a generated pattern of calibration points into ZBT SRAM through a
//   valid/ready write port. One pass writes NUM_POINTS words at BASE_ADDR+i;
//   optional looping restarts at point 0 with no bubble. A stop request ends
//   the pass at the next accepted point.
//
// Ports
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   start    : begin a pass (only honoured in IDLE)
//   mode     : pattern select sampled at start (0 diagonal, 1 raster)
//   loop_en  : sampled at start; restart at point 0 after the last point
//   stop     : abort request, honoured at the next accepted point
//   busy     : high while writing
//   done     : one-cycle pulse after a pass finishes
//   wr_valid : write request to the ZBT controller
//   wr_ready : ZBT controller accepts the write this cycle
//   wr_addr  : write address
//   wr_data  : {zero pad, x, y, colour}
// -----------------------------------------------------------------------------
module zbt_point_writer
  import zbt_point_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 19,
  parameter int unsigned        DATA_W     = 36,
  parameter int unsigned        COORD_W    = 10,
  parameter int unsigned        COLOR_W    = 10,
  parameter int unsigned        NUM_POINTS = 8,
  parameter int unsigned        BASE_ADDR  = 0,
  parameter int unsigned        X0         = 100,
  parameter int unsigned        Y0         = 100,
  parameter int unsigned        STEP       = 100,
  parameter int unsigned        GRID_W     = 4,
  parameter logic [COLOR_W-1:0] COLOR_A    = 10'b1111_1111_00,
  parameter logic [COLOR_W-1:0] COLOR_B    = 10'b0011_1111_00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic              loop_en,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);

  state_e            state_q;
  mode_e             mode_q;
  logic              loop_q;
  logic              stop_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;

  logic               accept;
  logic               stop_seen;
  logic               wrap;
  logic               gen_clear;
  logic               gen_advance;
  logic               gen_mode;
  logic               gen_last;
  logic [COORD_W-1:0] gen_x;
  logic [COORD_W-1:0] gen_y;
  logic [COLOR_W-1:0] gen_color;

  assign accept    = (state_q == WRITE) && valid_q && wr_ready;
  // A stop arriving in the same cycle as an acceptance counts: the point on
  // the bus completes and nothing further is presented.
  assign stop_seen = stop_q | stop;
  assign wrap      = accept && gen_last && loop_q && !stop_seen;

  assign gen_clear   = ((state_q == IDLE) && start) || wrap;
  assign gen_advance = accept && !gen_last && !stop_seen;
  // At start the generator must see the live mode pin; afterwards the latched
  // copy so a mid-pass change on the pin has no effect.
  assign gen_mode    = (state_q == IDLE) ? mode : mode_q;

  zbt_point_gen #(
    .COORD_W    (COORD_W),
    .COLOR_W    (COLOR_W),
    .NUM_POINTS (NUM_POINTS),
    .X0         (X0),
    .Y0         (Y0),
    .STEP       (STEP),
    .GRID_W     (GRID_W),
    .COLOR_A    (COLOR_A),
    .COLOR_B    (COLOR_B)
  ) u_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (gen_clear),
    .advance_i (gen_advance),
    .mode_i    (gen_mode),
    .x_o       (gen_x),
    .y_o       (gen_y),
    .color_o   (gen_color),
    .last_o    (gen_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_DIAG;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= BASE_C;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= WRITE;
            mode_q  <= mode_e'(mode);
            loop_q  <= loop_en;
            stop_q  <= 1'b0;
            addr_q  <= BASE_C;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        WRITE: begin
          if (stop) begin
            stop_q <= 1'b1;
          end
          if (accept) begin
            if (gen_advance) begin
              addr_q <= addr_q + ADDR_W'(1);
            end else if (wrap) begin
              addr_q <= BASE_C;
            end else begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_valid = valid_q;
  assign wr_addr  = addr_q;
  assign wr_data  = DATA_W'(pack_point(32'(gen_x), 32'(gen_y), 32'(gen_color),
                                       COORD_W, COLOR_W));

endmodule
